npu_matrix_loader: RTL and testbench

Loads one N×N signed 16-bit operand matrix from the NPU's synchronous on-chip RAM into a register array for the systolic array stage. Sits directly upstream of the systolic array and replaces the hard-wired matrix initialisation in the NPU top. It issues N*N sequential row-major reads from a programmable base address and places each returned word at its [row][col] position. A one-cycle `done` pulse and a level `matrix_valid` tell the systolic array when the operand is stable.

---
 rtl/npu_pkg.sv | 17 +
 rtl/npu_valid_delay.sv | 29 ++
 rtl/npu_matrix_loader.sv | 138 +++++++++++++
 tb/tb_npu_matrix_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types: element/matrix typedefs and the matrix loader state encoding.
package npu_pkg;

    localparam int NPU_N      = 10;
    localparam int NPU_DATA_W = 16;

    typedef logic signed [NPU_DATA_W-1:0] npu_elem_t;
    typedef npu_elem_t npu_matrix_t [NPU_N][NPU_N];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/npu_valid_delay.sv
// Shift register that delays the RAM read strobe so it lines up with returning read data.
module npu_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sr <= '0;
                else     r_sr <= i_valid;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sr <= '0;
                else     r_sr <= {r_sr[DEPTH-2:0], i_valid};
            end
        end
    endgenerate

    assign o_valid = r_sr[DEPTH-1];

endmodule

// File: rtl/npu_matrix_loader.sv
// Loads an N x N operand matrix from synchronous RAM (row-major, from a base address)
// into a register array for the systolic array stage.
//
// state | meaning
// IDLE  | waiting for start; matrix_valid holds the last completed load
// ISSUE | one read strobe per cycle, base + k for k = 0..N*N-1
// DRAIN | strobes stopped, waiting for the last read data to be captured
// DONE  | one-cycle done pulse, matrix_valid rises
module npu_matrix_loader
    import npu_pkg::*;
#(
    parameter int N       = NPU_N,
    parameter int DATA_W  = NPU_DATA_W,
    parameter int ADDR_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     ram_rd_en,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     matrix_valid,
    output logic signed [DATA_W-1:0] matrix [N][N]
);

    localparam int TOTAL = N * N;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int RC_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(TOTAL - 1);
    localparam logic [RC_W-1:0]  LAST_RC = RC_W'(N - 1);

    loader_state_e r_state, w_next;

    logic [ADDR_W-1:0]        r_base;
    logic [CNT_W-1:0]         r_issue_cnt;
    logic [RC_W-1:0]          r_row;
    logic [RC_W-1:0]          r_col;
    logic                     r_last_cap;
    logic                     r_matrix_valid;
    logic signed [DATA_W-1:0] r_matrix [N][N];
    logic                     w_accept;
    logic                     w_cap;

    assign w_accept = (r_state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ram_rd_en = 1'b0;
        ram_addr  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = ISSUE;
            end
            ISSUE: begin
                ram_rd_en = 1'b1;
                ram_addr  = r_base + ADDR_W'(r_issue_cnt);
                busy      = 1'b1;
                if (r_issue_cnt == LAST_K) w_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_last_cap) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // w_cap marks the cycle in which ram_rdata belongs to the oldest outstanding read
    npu_valid_delay #(
        .DEPTH (RAM_LAT)
    ) u_valid_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (ram_rd_en),
        .o_valid (w_cap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base         <= '0;
            r_issue_cnt    <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_last_cap     <= 1'b0;
            r_matrix_valid <= 1'b0;
        end else if (w_accept) begin
            r_base         <= base_addr;
            r_issue_cnt    <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_last_cap     <= 1'b0;
            r_matrix_valid <= 1'b0;
        end else begin
            if (r_state == ISSUE) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (w_cap) begin
                if (r_col == LAST_RC) begin
                    r_col <= '0;
                    r_row <= r_row + RC_W'(1);
                end else begin
                    r_col <= r_col + RC_W'(1);
                end
                if ((r_row == LAST_RC) && (r_col == LAST_RC)) r_last_cap <= 1'b1;
            end
            if ((r_state == DRAIN) && r_last_cap) r_matrix_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_matrix[r][c] <= '0;
                end
            end
        end else if (w_cap) begin
            r_matrix[r_row][r_col] <= ram_rdata;
        end
    end

    assign matrix       = r_matrix;
    assign matrix_valid = r_matrix_valid;

endmodule

// File: tb/tb_npu_matrix_loader.sv
// Scoreboard bench for npu_matrix_loader: three instances (RAM_LAT 1, 2, 4) share stimulus,
// a transaction-level model predicts strobes, done timing and matrix contents.
module tb_npu_matrix_loader;

    localparam int N  = 10;
    localparam int NN = N * N;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    int          mode = 0;

    always #5 clk = ~clk;

    logic [NI-1:0]                          rd_en, busy, done, mvalid, allzero;
    logic [NI-1:0][15:0]                    raddr;
    logic [NI-1:0][N-1:0][N-1:0][15:0]      mat;

    function automatic logic [15:0] mem_val(input logic [15:0] a, input int md);
        case (md)
            0:       return a;
            1:       return 16'h0000 - a;
            default: return (a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g
        localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
        logic               re, bz, dn, mv, allz;
        logic [15:0]        ra, rdata;
        logic [15:0]        pipe [4];
        logic signed [15:0] m [N][N];

        npu_matrix_loader #(
            .N(N), .DATA_W(16), .ADDR_W(16), .RAM_LAT(L)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
            .ram_rd_en(re), .ram_addr(ra), .ram_rdata(rdata),
            .busy(bz), .done(dn), .matrix_valid(mv), .matrix(m)
        );

        // RAM model: data appears L cycles after its strobe
        always @(posedge clk) begin
            pipe[0] <= re ? mem_val(ra, mode) : 16'hDEAD;
            for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
        end
        assign rdata = pipe[L-1];

        always_comb begin
            allz = 1'b1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (m[i][j] != 16'sd0) allz = 1'b0;
        end

        assign rd_en[gi]   = re;
        assign busy[gi]    = bz;
        assign done[gi]    = dn;
        assign mvalid[gi]  = mv;
        assign allzero[gi] = allz;
        assign raddr[gi]   = ra;
        for (genvar r = 0; r < N; r++) begin : g_r
            for (genvar c = 0; c < N; c++) begin : g_c
                assign mat[gi][r][c] = m[r][c];
            end
        end
    end

    typedef struct { logic [15:0] addr; int ec; } strb_t;
    typedef struct { logic [15:0] base; int md; int ec; } ld_t;

    strb_t sq [NI][$];
    ld_t   dq [NI][$];
    int    free_at [NI];
    int    ec = 0;
    int    n_assert = 0;
    int    n_fail = 0;
    strb_t s_pop;
    ld_t   d_pop;
    int    nbad;
    int    first_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_assert++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < NI; i++) p += sq[i].size() + dq[i].size();
        return p;
    endfunction

    task automatic pulse(input logic [15:0] b, input int md);
        @(negedge clk);
        base_addr = b;
        mode      = md;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pending() != 0 || busy != '0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle timeout", 64'(n >= 3000), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            // reference model: accepted loads produce expected strobes and done events
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    for (int i = 0; i < NI; i++) begin
                        sq[i].delete();
                        dq[i].delete();
                        free_at[i] = 0;
                    end
                end else begin
                    ec++;
                    for (int i = 0; i < NI; i++) begin
                        if (start && ec >= free_at[i]) begin
                            for (int k = 0; k < NN; k++)
                                sq[i].push_back('{base_addr + 16'(k), ec + k});
                            dq[i].push_back('{base_addr, mode, ec + NN + lat_of(i) + 1});
                            free_at[i] = ec + NN + lat_of(i) + 3;
                        end
                    end
                end
            end
            // monitor
            forever begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    if (rd_en[i]) begin
                        if (sq[i].size() == 0) flag($sformatf("unexpected strobe L%0d addr %0h", lat_of(i), raddr[i]));
                        else begin
                            s_pop = sq[i].pop_front();
                            chk($sformatf("strobe addr L%0d", lat_of(i)), 64'(raddr[i]), 64'(s_pop.addr));
                            chk($sformatf("strobe cycle L%0d", lat_of(i)), 64'(ec), 64'(s_pop.ec));
                            chk($sformatf("busy while issuing L%0d", lat_of(i)), 64'(busy[i]), 64'd1);
                        end
                    end
                    if (done[i]) begin
                        if (dq[i].size() == 0) flag($sformatf("unexpected done L%0d", lat_of(i)));
                        else begin
                            d_pop = dq[i].pop_front();
                            chk($sformatf("done cycle L%0d", lat_of(i)), 64'(ec), 64'(d_pop.ec));
                            chk($sformatf("matrix_valid at done L%0d", lat_of(i)), 64'(mvalid[i]), 64'd1);
                            chk($sformatf("busy low at done L%0d", lat_of(i)), 64'(busy[i]), 64'd0);
                            nbad = 0;
                            first_bad = -1;
                            for (int r = 0; r < N; r++)
                                for (int c = 0; c < N; c++)
                                    if (mat[i][r][c] !== mem_val(d_pop.base + 16'(N*r + c), d_pop.md)) begin
                                        if (first_bad < 0) first_bad = N*r + c;
                                        nbad++;
                                    end
                            chk($sformatf("matrix bad elements L%0d base %0h first %0d", lat_of(i), d_pop.base, first_bad),
                                64'(nbad), 64'd0);
                        end
                    end
                end
            end
        join_none

        // reset state
        repeat (3) @(negedge clk);
        chk("reset rd_en", 64'(rd_en), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset matrix_valid", 64'(mvalid), 64'd0);
        chk("reset ram_addr", 64'(raddr), 64'd0);
        chk("reset matrix zero", 64'(allzero), 64'h7);
        rst = 1'b0;

        // identity contents at 0x0040
        pulse(16'h0040, 0);
        wait_idle();
        chk("matrix[3][7] identity", 64'(mat[0][3][7]), 64'h0040 + 64'd37);
        chk("matrix[9][9] identity", 64'(mat[0][9][9]), 64'h00A3);
        chk("matrix_valid held in idle", 64'(mvalid), 64'h7);

        // negated contents, sign check across latencies
        pulse(16'h0000, 1);
        wait_idle();
        for (int i = 0; i < NI; i++)
            chk($sformatf("neg matrix[9][9] L%0d", lat_of(i)), 64'(mat[i][9][9]), 64'hFF9D);

        // address wrap
        pulse(16'hFFF0, 2);
        wait_idle();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("wrap [1][5] L%0d", lat_of(i)), 64'(mat[i][1][5]), 64'(mem_val(16'hFFFF, 2)));
            chk($sformatf("wrap [1][6] L%0d", lat_of(i)), 64'(mat[i][1][6]), 64'(mem_val(16'h0000, 2)));
        end

        // start re-pulsed while busy and during DONE
        pulse(16'h1200, 0);
        repeat (18) @(negedge clk);
        pulse(16'h3400, 0);
        begin
            int n = 0;
            while (!done[0] && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("done seen for busy-ignore", 64'(done[0]), 64'd1);
            base_addr = 16'h5600;
            start     = 1'b1;
            @(negedge clk);
            start     = 1'b0;
        end
        wait_idle();

        // start held high: back-to-back loads, base changes every cycle
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t < 250; t++) begin
            base_addr = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // asynchronous reset mid-ISSUE
        pulse(16'h0800, 2);
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst rd_en", 64'(rd_en), 64'd0);
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        chk("async rst matrix_valid", 64'(mvalid), 64'd0);
        chk("async rst matrix zero", 64'(allzero), 64'h7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        chk("no load after reset", 64'(allzero), 64'h7);
        pulse(16'h0900, 1);
        wait_idle();

        // randomized loads with stray start pulses while busy
        for (int it = 0; it < 6; it++) begin
            pulse(16'($urandom), int'($urandom_range(0, 2)));
            repeat ($urandom_range(1, 90)) @(negedge clk);
            pulse(16'($urandom), mode);
            wait_idle();
        end

        chk("scoreboard drained", 64'(pending()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
